// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, grant and sizing constants
// for the icache/dcache to main-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I_FILL,
    ST_D_RD,
    ST_D_WR,
    ST_I_RESP,
    ST_D_RESP
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int BEATS_PER_IBLOCK = 4;
  localparam int DATA_BASE_DEF    = 256;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: 32-bit busywait-handshaked main-memory port.
// master = arbiter side, slave = memory side.
interface mem_arbiter_if #(
  parameter int MEM_AW = 9
) ();

  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_busywait;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_writedata,
    input  mem_readdata,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_writedata,
    output mem_readdata,
    output mem_busywait
  );

endinterface

// File: rtl/mem_beat_ctrl.sv
// mem_beat_ctrl: drives one memory strobe per beat and flags
// completion once busywait has been seen high then low.
module mem_beat_ctrl (
  input  logic CLK,
  input  logic RESET,
  input  logic req,
  input  logic wr,
  input  logic mem_busywait,
  output logic mem_read,
  output logic mem_write,
  output logic beat_done
);

  logic busy_seen;
  logic active;

  assign active    = mem_read | mem_write;
  assign beat_done = active & busy_seen & ~mem_busywait;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy_seen <= 1'b0;
    end else if (active) begin
      // low busywait before any busy cycle is not a completion
      if (mem_busywait) begin
        busy_seen <= 1'b1;
      end else if (busy_seen) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        busy_seen <= 1'b0;
      end
    end else if (req) begin
      mem_read  <= ~wr;
      mem_write <= wr;
      busy_seen <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache 4-beat refills and dcache reads/write-backs
// onto one memory port. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_AW    = 9,
  parameter int DATA_BASE = DATA_BASE_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_memread,
  input  logic [5:0]    i_memaddress,
  output logic [127:0]  i_memreaddata,
  output logic          i_membusywait,
  input  logic          d_memread,
  input  logic          d_memwrite,
  input  logic [5:0]    d_memaddress,
  input  logic [31:0]   d_memwritedata,
  output logic [31:0]   d_memreaddata,
  output logic          d_membusywait,
  mem_arbiter_if.master mem
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [1:0] BEAT_LAST = 2'(BEATS_PER_IBLOCK - 1);

  state_t            state;
  gnt_t              grant_last;
  logic [1:0]        beat;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              d_req;
  logic              i_req;
  logic              pick_i;
  logic              pick_d;
  logic              beat_req;
  logic              beat_wr;
  logic              beat_done;
  logic              rd_s;
  logic              wr_s;
  logic [MEM_AW-1:0] d_addr;
  logic [MEM_AW-1:0] i_addr;

  assign d_req = d_memread | d_memwrite;
  assign i_req = i_memread;

  // dcache wins unless round-robin says it was served last
  assign pick_i = i_req &
    (~d_req | (RR_EN & (grant_last == GNT_D)));
  assign pick_d = d_req & ~pick_i;

  assign d_addr = MEM_AW'(DATA_BASE)
                + MEM_AW'(d_memaddress);
  assign i_addr = MEM_AW'({i_memaddress, 2'b00});

  assign beat_req =
    ((state == ST_IDLE) & (d_req | i_req)) |
    (state == ST_I_FILL);
  assign beat_wr =
    (state == ST_IDLE) & pick_d & d_memwrite;

  assign i_membusywait = ~RESET & i_memread
                       & (state != ST_I_RESP);
  assign d_membusywait = ~RESET & d_req
                       & (state != ST_D_RESP);

  assign mem.mem_read      = rd_s;
  assign mem.mem_write     = wr_s;
  assign mem.mem_address   = addr_q;
  assign mem.mem_writedata = wdata_q;

  mem_beat_ctrl u_beat (
    .CLK          (CLK),
    .RESET        (RESET),
    .req          (beat_req),
    .wr           (beat_wr),
    .mem_busywait (mem.mem_busywait),
    .mem_read     (rd_s),
    .mem_write    (wr_s),
    .beat_done    (beat_done)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      grant_last    <= GNT_D;
      beat          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      i_memreaddata <= '0;
      d_memreaddata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat <= '0;
          if (pick_d) begin
            addr_q  <= d_addr;
            wdata_q <= d_memwritedata;
            state   <= d_memwrite ? ST_D_WR : ST_D_RD;
          end else if (pick_i) begin
            addr_q <= i_addr;
            state  <= ST_I_FILL;
          end
        end
        ST_I_FILL: begin
          if (beat_done) begin
            i_memreaddata[{beat, 5'd0} +: 32]
              <= mem.mem_readdata;
            if (beat == BEAT_LAST) begin
              state <= ST_I_RESP;
            end else begin
              beat   <= beat + 2'd1;
              addr_q <= addr_q + MEM_AW'(1);
            end
          end
        end
        ST_D_RD: begin
          if (beat_done) begin
            d_memreaddata <= mem.mem_readdata;
            state         <= ST_D_RESP;
          end
        end
        ST_D_WR: begin
          if (beat_done) state <= ST_D_RESP;
        end
        ST_I_RESP: begin
          grant_last <= GNT_I;
          state      <= ST_IDLE;
        end
        ST_D_RESP: begin
          grant_last <= GNT_D;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of inst_cache and dcache, upstream of a single unified main memory.
- Serialises icache block refills (128-bit block, fetched as 4 x 32-bit beats) and dcache block reads and write-backs (32-bit block, 1 beat) onto one 32-bit, busywait-handshaked memory port.
- Presents each cache with the same miss interface it drives today: level request, busywait, and read data.

Parameters:
- MEM_AW, 9, main-memory word-address width (512 x 32-bit words).
- DATA_BASE, 256, word offset added to dcache block addresses; icache occupies words 0..255.

Ports:
- CLK  in  1  system clock, posedge.
- RESET  in  1  asynchronous, active-high reset.
- i_memread  in  1  icache refill request, held until serviced.
- i_memaddress  in  6  icache block address.
- i_memreaddata  out  128  refilled block, beat0 in [31:0].
- i_membusywait  out  1  icache stall.
- d_memread  in  1  dcache block read request.
- d_memwrite  in  1  dcache write-back request.
- d_memaddress  in  6  dcache block address.
- d_memwritedata  in  32  write-back block.
- d_memreaddata  out  32  read block.
- d_membusywait  out  1  dcache stall.
- mem_read  out  1  main-memory read strobe (level).
- mem_write  out  1  main-memory write strobe (level).
- mem_address  out  MEM_AW  main-memory word address.
- mem_writedata  out  32  main-memory write data.
- mem_readdata  in  32  main-memory read data.
- mem_busywait  in  1  main-memory busy.

Behaviour:
- Reset (async, RESET=1): state=IDLE, beat=0, grant_last=D.
  - All outputs 0: mem_read, mem_write, mem_address, mem_writedata, i_membusywait, d_membusywait, i_memreaddata, d_memreaddata.
- States: IDLE, I_FILL, D_RD, D_WR, I_RESP, D_RESP.
- Busywaits:
  - i_membusywait = i_memread && state!=I_RESP.
  - d_membusywait = (d_memread||d_memwrite) && state!=D_RESP.
  - Both are combinational, so a waiting cache is stalled from the cycle its request rises.
- IDLE arbitration, evaluated at posedge:
  - Default is fixed priority, dcache over icache.
  - d_memwrite with d_memread both high: write wins and goes to D_WR; the read is serviced as a later request.
  - Next state: D_WR, D_RD or I_FILL (beat=0); else stay in IDLE.
- Memory beat handshake:
  - Arbiter holds mem_read or mem_write and mem_address stable.
  - A beat completes on the first posedge where mem_busywait==0, with busy_seen set after at least one sampled busywait==1 cycle.
  - mem_read/mem_write deassert in the cycle after completion.
  - mem_busywait stuck low never completes a beat; this is documented, no timeout.
- I_FILL:
  - Beat address = {i_memaddress,2'b00}+beat, zero-extended to MEM_AW.
  - On beat completion, mem_readdata is latched into i_memreaddata[32*beat+:32] and beat increments.
  - Strobe drops for exactly one cycle between beats.
  - After beat 3 completes: go to I_RESP.
- D_RD: address = DATA_BASE+d_memaddress; on completion latch d_memreaddata, go to D_RESP.
- D_WR: address as D_RD, mem_writedata = d_memwritedata; on completion go to D_RESP.
- I_RESP / D_RESP:
  - Exactly one cycle; the matching busywait is low so the cache samples data and drops its request.
  - Next state is IDLE; grant_last is updated.
- Requests arriving during a transfer are not sampled until IDLE; they only see busywait high.
- A request withdrawn mid-transfer (protocol violation) does not abort the transfer; the burst completes.
- Latency:
  - dcache: arbitration cycle + memory beat + 1 response cycle.
  - icache: arbitration cycle + 4 beats + 3 gap cycles + 1 response cycle.
- Reset mid-transfer: immediate return to IDLE, strobes dropped, partial block discarded.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration; when both caches request in IDLE, grant the cache not in grant_last.
- ARB_RR_EN undefined: fixed dcache priority as above; grant_last is still maintained but unused.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE..ST_D_RESP;
  - BEATS_PER_IBLOCK=4;
  - DATA_BASE default;
  - grant ID constants GNT_I/GNT_D.
- One natural sub-module, mem_beat_ctrl: drives the strobe, tracks busy_seen and emits beat_done.
- The arbiter FSM, beat counter and refill assembly stay in mem_arbiter.

Test Plan:
- icache-only refill:
  - Stimulus: i_memread=1, i_memaddress=6'h02; memory returns words 8..11 = 32'hA0..A3, each with busywait=1 for 3 cycles.
  - Expect: mem_address sequence 8,9,10,11; i_memreaddata={A3,A2,A1,A0}; i_membusywait low for exactly one cycle.
- dcache write-back:
  - Stimulus: d_memwrite=1, d_memaddress=6'h05, d_memwritedata=32'hDEADBEEF.
  - Expect: mem_write with mem_address=261 and that data; d_membusywait drops one cycle after completion.
- Simultaneous requests, default build:
  - Stimulus: d_memread (address 6'h01) and i_memread both raised in the same cycle.
  - Expect: dcache served first (address 257), then the icache burst.
  - Under ARB_RR_EN with grant_last=D after reset: icache served first.
- Write+read from dcache in the same cycle:
  - Expect: D_WR first; the read is serviced in the next arbitration.
- Async RESET pulse during icache beat 2:
  - Expect: within the same cycle, mem_read=0, all busywaits 0 and state IDLE.
  - A new i_memread then restarts from beat 0.
- Back-to-back dcache reads:
  - Stimulus: addresses 6'h03 then 6'h04.
  - Expect: exactly one IDLE cycle between transfers; d_memreaddata is correct for each.
